// File: rtl/ama_riscv_branch_predictor.sv
// Direct-mapped, tagged branch predictor with saturating counters and stored targets.
// A sweep FSM (INIT) invalidates the table after reset or flush; lookups answer one cycle later.
module ama_riscv_branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic        ready,
    input  logic        lkp_valid,
    input  logic [31:0] lkp_pc,
    input  logic        lkp_hold,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_jump,
    input  logic        upd_pred_taken,
    output logic [31:0] stat_upd,
    output logic [31:0] stat_mispred,
    output logic        dbg_state_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(2 ** (CNT_W - 1) - 1);

    typedef enum logic {S_INIT = 1'b0, S_IDLE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_q, sweep_d;
    logic               clr_en;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0]   lkp_idx, upd_idx;
    logic [TAG_W-1:0]   lkp_tag, upd_tag;
    logic               lkp_hit, upd_acc, upd_hit;
    logic [CNT_W-1:0]   upd_cur;
    logic               wr_en, wr_tgt_en;
    logic [CNT_W-1:0]   wr_cnt;
    logic               unused_pc_bits;

    assign ready       = (state_q == S_IDLE);
    assign dbg_state_o = logic'(state_q);

    // flush/restart always wins, even mid-sweep
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        clr_en  = 1'b0;
        case (state_q)
            S_INIT: begin
                clr_en  = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = S_IDLE;
            end
            default: ;
        endcase
        if (flush) begin
            state_d = S_INIT;
            sweep_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign lkp_idx = lkp_pc[IDX_W+1:2];
    assign lkp_tag = lkp_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits = ^{lkp_pc[31:IDX_W+TAG_W+2], lkp_pc[1:0],
                              upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

    assign lkp_hit = lkp_valid && ready && valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign upd_acc = upd_valid && ready;
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_cur = cnt_q[upd_idx];

    always_comb begin
        wr_en     = 1'b0;
        wr_tgt_en = 1'b0;
        wr_cnt    = upd_cur;
        if (upd_acc) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_jump) begin
                    wr_cnt    = CNT_MAX;
                    wr_tgt_en = 1'b1;
                end else if (upd_taken) begin
                    wr_cnt    = (upd_cur == CNT_MAX) ? upd_cur : upd_cur + 1'b1;
                    wr_tgt_en = 1'b1;
                end else begin
                    wr_cnt    = (upd_cur == '0) ? upd_cur : upd_cur - 1'b1;
                end
            end else if (upd_taken) begin
                wr_en     = 1'b1;
                wr_tgt_en = 1'b1;
                wr_cnt    = upd_jump ? CNT_MAX : CNT_WT;
            end
        end
    end

    // Sweep and updates never overlap: the sweep runs only while ready is low.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[sweep_q] <= 1'b0;
            cnt_q[sweep_q]   <= CNT_WNT;
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            cnt_q[upd_idx]   <= wr_cnt;
            if (wr_tgt_en) tgt_q[upd_idx] <= upd_target;
        end
    end

    // Table reads here see pre-update contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!lkp_hold) begin
            pred_hit    <= lkp_hit;
            pred_taken  <= lkp_hit && cnt_q[lkp_idx][CNT_W-1];
            pred_target <= (lkp_valid && ready) ? tgt_q[lkp_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd     <= '0;
            stat_mispred <= '0;
        end else if (upd_acc) begin
            stat_upd <= stat_upd + 32'd1;
            if (upd_pred_taken != upd_taken) stat_mispred <= stat_mispred + 32'd1;
        end
    end

endmodule

// File: doc/ama_riscv_branch_predictor.md
AMA_RISCV_BRANCH_PREDICTOR -- requirements
Module: ama_riscv_branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of table entries; power of 2, range 4..1024.
REQ-002 SHALL have parameter CNT_W, default 2, saturating counter width; range 1..4.
REQ-003 SHALL have parameter TAG_W, default 8, stored tag width; range 1..16.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port flush, input, 1, synchronous table invalidate request.
REQ-007 SHALL have port ready, output, 1, high when the table is usable (IDLE state).
REQ-008 SHALL have port lkp_valid, input, 1, lookup request (IF stage, next-PC).
REQ-009 SHALL have port lkp_pc, input, 32, lookup address.
REQ-010 SHALL have port lkp_hold, input, 1, freeze lookup outputs (driven from stall_if).
REQ-011 SHALL have ports pred_hit (1), pred_taken (1) and pred_target (32), all outputs, carrying the lookup result in the cycle after the request.
REQ-012 SHALL have ports upd_valid (1), upd_pc (32), upd_taken (1), upd_target (32), upd_jump (1) and upd_pred_taken (1), all inputs, carrying the resolved branch from the EX stage.
REQ-013 SHALL have ports stat_upd (32) and stat_mispred (32), both outputs, carrying the update and mispredict counts.

Function
REQ-014 IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; bits above the tag are ignored (aliasing permitted).
REQ-015 Entry = {valid, tag[TAG_W], cnt[CNT_W], target[32]}; SHALL predict taken iff cnt >= 2^(CNT_W-1).
REQ-016 FSM states: INIT and IDLE.
  - INIT clears one entry per cycle (valid=0, cnt=2^(CNT_W-1)-1), index 0 to ENTRIES-1, then goes to IDLE.
  - ready=0 in INIT.
REQ-017 rst or flush SHALL enter INIT with the sweep index set to 0, including mid-sweep (restart) and mid-operation.
REQ-018 Lookup latency SHALL be exactly 1 cycle: outputs register the result for lkp_pc sampled when lkp_valid=1 and lkp_hold=0.
REQ-019 lkp_hold=1 SHALL hold all pred_* outputs unchanged, regardless of lkp_valid.
REQ-020 lkp_valid=0 with lkp_hold=0 SHALL drive pred_hit=0 and pred_taken=0 next cycle; pred_target is don't-care, driven 0.
REQ-021 pred_hit=1 iff ready, entry valid and tag match; pred_taken = pred_hit AND counter MSB condition; pred_target = stored target.
REQ-022 A lookup while ready=0 SHALL return pred_hit=0 and pred_taken=0.
REQ-023 Update, hit, branch (upd_jump=0): cnt+1 if taken, else cnt-1, saturating at 2^CNT_W-1 and 0; target overwritten only if taken.
REQ-024 Update, hit, jump (upd_jump=1): cnt set to 2^CNT_W-1, target overwritten.
REQ-025 Update, miss, taken: allocate the entry (valid=1, new tag, target=upd_target, cnt=2^(CNT_W-1), or max if jump), replacing any previous occupant.
REQ-026 Update, miss, not taken: no table change.
REQ-027 Updates SHALL be ignored while ready=0, and SHALL NOT be counted.
REQ-028 Same-cycle lookup and update to the same index: the lookup SHALL return pre-update contents (read-before-write).
REQ-029 stat_upd SHALL increment on each accepted update; stat_mispred SHALL increment when upd_pred_taken != upd_taken; both wrap modulo 2^32.
REQ-030 flush SHALL NOT clear the stat counters.

Reset
REQ-031 On rst: state=INIT, sweep index=0, ready=0, pred_hit=0, pred_taken=0, pred_target=0, stat_upd=0, stat_mispred=0.
REQ-032 After rst deasserts, ready SHALL rise exactly ENTRIES cycles later (64 with defaults), with every entry invalid.

Verification
REQ-033 Init: release rst, hold flush=0 -> ready=0 for 64 cycles, then 1; lookup pc=0x100 -> pred_hit=0.
REQ-034 Allocate and saturate: update pc=0x100, taken, target=0x40 -> next lookup gives hit=1, taken=1, target=0x40; after 3 more taken updates cnt=3; then 2 not-taken updates -> taken=0 (cnt=1); further not-taken updates hold cnt=0.
REQ-035 Aliasing: allocate pc=0x100, then look up pc=0x100+4*64 (same index, different tag) -> pred_hit=0; a taken update to the alias replaces the entry, and lookup of 0x100 then misses.
REQ-036 Same-cycle access: entry cnt=1, lookup and taken update of pc=0x100 in the same cycle -> pred_taken=0; the next lookup -> pred_taken=1.
REQ-037 Hold and flush: lkp_hold=1 for 3 cycles with changing lkp_pc -> pred_* stable; flush at sweep index 30 -> ready low for a further 64 cycles, stats retained.
REQ-038 Stats: 5 updates, 2 of them with upd_pred_taken != upd_taken -> stat_upd=5, stat_mispred=2; preload stat_upd=0xFFFFFFFF, apply one update -> stat_upd=0.
